// File: rtl/dm_pipe.sv
module dm_pipe #(
  parameter int unsigned DEPTH_LOG2   = 10,
  parameter int unsigned LOAD_LATENCY = 1,
  parameter string       INIT_FILE    = ""
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault
);

  localparam int unsigned WORDS = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  logic [31:0] mem_q [WORDS];

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] hold_q, hold_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic        sgn_q, sgn_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_fault_q, resp_fault_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic                  accept;
  logic                  fault;
  logic                  do_store;
  logic [DEPTH_LOG2-1:0] idx;
  logic [3:0]            be;
  logic [31:0]           wlane;

  initial for (int unsigned i = 0; i < WORDS; i++) mem_q[i] = '0;

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] off, input logic sgn);
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    half_v = off[1] ? word[31:16] : word[15:0];
    byte_v = word[8*off +: 8];
    case (size)
      2'b00:   return word;
      2'b01:   return {{16{sgn & half_v[15]}}, half_v};
      2'b10:   return {{24{sgn & byte_v[7]}}, byte_v};
      default: return '0;
    endcase
  endfunction

  assign req_ready = (state_q != WAIT);
  assign accept    = req_valid && req_ready;
  assign idx       = req_addr[DEPTH_LOG2+1:2];
  assign fault     = (req_size == 2'b11)
                  || (req_size == 2'b01 && req_addr[0])
                  || (req_size == 2'b00 && req_addr[1:0] != 2'b00)
                  || (|(req_addr >> (DEPTH_LOG2 + 2)));
  assign do_store  = accept && req_write && !fault;

  always_comb begin
    be    = '0;
    wlane = req_wdata;
    case (req_size)
      2'b00: be = '1;
      2'b01: begin
        be    = req_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        be    = 4'b0001 << req_addr[1:0];
        wlane = {4{req_wdata[7:0]}};
      end
      default: be = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    size_d       = size_q;
    off_d        = off_q;
    sgn_d        = sgn_q;
    resp_valid_d = 1'b0;
    resp_fault_d = 1'b0;
    resp_rdata_d = '0;
    case (state_q)
      WAIT: begin
        if (cnt_q <= 3'd1) begin
          state_d      = RESP;
          cnt_d        = '0;
          resp_valid_d = 1'b1;
          resp_rdata_d = extract(hold_q, size_q, off_q, sgn_q);
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          if (fault || req_write) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = fault;
          end else begin
            // Word is captured now; lane select/extension use the latched request fields.
            hold_d = mem_q[idx];
            size_d = req_size;
            off_d  = req_addr[1:0];
            sgn_d  = req_signed;
            if (LOAD_LATENCY <= 1) begin
              state_d      = RESP;
              resp_valid_d = 1'b1;
              resp_rdata_d = extract(mem_q[idx], req_size, req_addr[1:0], req_signed);
            end else begin
              state_d = WAIT;
              cnt_d   = 3'(LOAD_LATENCY - 1);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hold_q       <= '0;
      size_q       <= '0;
      off_q        <= '0;
      sgn_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      size_q       <= size_d;
      off_q        <= off_d;
      sgn_q        <= sgn_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n && do_store) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_fault = resp_fault_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dm_pipe.sv
// Directed bench for dm_pipe: back-to-back vector table on a LOAD_LATENCY=1 instance,
// hand sequences for latency, stall and reset behaviour on a LOAD_LATENCY=4 instance.
module tb_dm_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // LOAD_LATENCY=1 instance
    logic        rst1_n, v1, rdy1, w1, sg1, rv1, rf1;
    logic [1:0]  sz1;
    logic [31:0] a1, wd1, rd1;
    // LOAD_LATENCY=4 instance
    logic        rst4_n, v4, rdy4, w4, sg4, rv4, rf4;
    logic [1:0]  sz4;
    logic [31:0] a4, wd4, rd4;

    dm_pipe #(.DEPTH_LOG2(10), .LOAD_LATENCY(1)) dut1 (
        .clock(clk), .reset_n(rst1_n), .req_valid(v1), .req_ready(rdy1), .req_write(w1),
        .req_size(sz1), .req_signed(sg1), .req_addr(a1), .req_wdata(wd1),
        .resp_valid(rv1), .resp_rdata(rd1), .resp_fault(rf1));

    dm_pipe #(.DEPTH_LOG2(10), .LOAD_LATENCY(4)) dut4 (
        .clock(clk), .reset_n(rst4_n), .req_valid(v4), .req_ready(rdy4), .req_write(w4),
        .req_size(sz4), .req_signed(sg4), .req_addr(a4), .req_wdata(wd4),
        .resp_valid(rv4), .resp_rdata(rd4), .resp_fault(rf4));

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        ef;
        logic [31:0] er;
    } vec_t;

    vec_t vt[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                       input logic [31:0] wd, input logic ef, input logic [31:0] er);
        vec_t v;
        v.wr = wr; v.sz = sz; v.sg = sg; v.addr = addr; v.wd = wd; v.ef = ef; v.er = er;
        vt.push_back(v);
    endtask

    // Single request on dut4, issued at a negedge; waits (bounded) for the response.
    task automatic req4(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rdata, output logic flt, output int lat);
        @(negedge clk);
        v4 = 1'b1; w4 = wr; sz4 = sz; sg4 = sg; a4 = addr; wd4 = wd;
        chk("req4 ready", rdy4, 1'b1);
        @(negedge clk);
        v4 = 1'b0;
        lat = 1;
        while (!rv4 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        rdata = rd4;
        flt   = rf4;
    endtask

    initial begin
        logic [31:0] r;
        logic        f;
        int          lat;
        logic        seen;

        rst1_n = 1'b0; v1 = 1'b0; w1 = 1'b0; sz1 = '0; sg1 = 1'b0; a1 = '0; wd1 = '0;
        rst4_n = 1'b0; v4 = 1'b0; w4 = 1'b0; sz4 = '0; sg4 = 1'b0; a4 = '0; wd4 = '0;

        //   wr  sz    sg   addr           wdata          fault rdata
        add(1, 2'b00, 0, 32'h0000_0000, 32'h0BAD_F00D, 0, 32'h0);
        add(1, 2'b00, 0, 32'h0000_0010, 32'h1234_5678, 0, 32'h0);
        add(0, 2'b00, 0, 32'h0000_0010, 32'h0,         0, 32'h1234_5678);
        add(1, 2'b00, 0, 32'h0000_0020, 32'hCAFE_00AA, 0, 32'h0);
        add(1, 2'b10, 0, 32'h0000_0021, 32'hFFFF_FF80, 0, 32'h0);
        add(0, 2'b10, 1, 32'h0000_0021, 32'h0,         0, 32'hFFFF_FF80);
        add(0, 2'b10, 0, 32'h0000_0021, 32'h0,         0, 32'h0000_0080);
        add(1, 2'b01, 0, 32'h0000_0022, 32'h1234_BEEF, 0, 32'h0);
        add(0, 2'b01, 1, 32'h0000_0022, 32'h0,         0, 32'hFFFF_BEEF);
        add(0, 2'b01, 0, 32'h0000_0022, 32'h0,         0, 32'h0000_BEEF);
        add(0, 2'b00, 0, 32'h0000_0020, 32'h0,         0, 32'hBEEF_80AA);
        add(0, 2'b10, 1, 32'h0000_0020, 32'h0,         0, 32'hFFFF_FFAA);
        add(0, 2'b10, 0, 32'h0000_0023, 32'h0,         0, 32'h0000_00BE);
        add(0, 2'b01, 0, 32'h0000_0020, 32'h0,         0, 32'h0000_80AA);
        add(0, 2'b01, 1, 32'h0000_0012, 32'h0,         0, 32'h0000_1234);
        add(0, 2'b00, 0, 32'h0000_0013, 32'h0,         1, 32'h0);
        add(1, 2'b01, 0, 32'h0000_0001, 32'h0000_FFFF, 1, 32'h0);
        add(0, 2'b00, 0, 32'h0000_0000, 32'h0,         0, 32'h0BAD_F00D);
        add(0, 2'b11, 0, 32'h0000_0030, 32'h0,         1, 32'h0);
        add(1, 2'b00, 0, 32'h0000_1000, 32'hDEAD_BEEF, 1, 32'h0);
        add(0, 2'b00, 0, 32'h0000_1000, 32'h0,         1, 32'h0);
        add(0, 2'b00, 0, 32'h0000_0000, 32'h0,         0, 32'h0BAD_F00D);
        add(1, 2'b00, 0, 32'h0000_0FFC, 32'h5A5A_5A5A, 0, 32'h0);
        add(1, 2'b10, 0, 32'h0000_0FFF, 32'h0000_0011, 0, 32'h0);
        add(0, 2'b00, 0, 32'h0000_0FFC, 32'h0,         0, 32'h115A_5A5A);
        add(0, 2'b00, 0, 32'h8000_0000, 32'h0,         1, 32'h0);
        add(0, 2'b01, 0, 32'h0000_0011, 32'h0,         1, 32'h0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst1_n = 1'b1; rst4_n = 1'b1;
        chk("reset resp_valid", rv1, 1'b0);
        chk("reset resp_fault", rf1, 1'b0);
        chk("reset resp_rdata", rd1, 32'h0);
        chk("reset req_ready", rdy1, 1'b1);
        chk("reset4 req_ready", rdy4, 1'b1);
        chk("reset4 resp_valid", rv4, 1'b0);

        // Back-to-back table on LOAD_LATENCY=1: one accept per cycle
        foreach (vt[i]) begin
            @(negedge clk);
            v1 = 1'b1; w1 = vt[i].wr; sz1 = vt[i].sz; sg1 = vt[i].sg; a1 = vt[i].addr; wd1 = vt[i].wd;
            chk($sformatf("vec%0d ready", i), rdy1, 1'b1);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d valid", i), rv1, 1'b1);
            chk($sformatf("vec%0d fault", i), rf1, vt[i].ef);
            chk($sformatf("vec%0d rdata", i), rd1, vt[i].er);
        end
        @(negedge clk);
        v1 = 1'b0;
        @(posedge clk);
        #1;
        chk("idle valid", rv1, 1'b0);
        chk("idle rdata", rd1, 32'h0);
        chk("idle fault", rf1, 1'b0);

        // LOAD_LATENCY=4: preload, then latency/stall sequence
        req4(1, 2'b00, 0, 32'h40, 32'hA5A5_A5A5, r, f, lat);
        chk("l4 store lat", lat, 1);
        chk("l4 store rdata", r, 32'h0);
        req4(1, 2'b00, 0, 32'h4C, 32'h0000_004C, r, f, lat);
        req4(1, 2'b00, 0, 32'h48, 32'h0000_0077, r, f, lat);

        @(negedge clk);
        v4 = 1'b1; w4 = 1'b0; sz4 = 2'b00; sg4 = 1'b0; a4 = 32'h40;
        chk("lat load ready", rdy4, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                w4 = 1'b1; a4 = 32'h44; wd4 = 32'h1122_3344;
            end
            chk($sformatf("lat c%0d ready", c), rdy4, 1'b0);
            chk($sformatf("lat c%0d valid", c), rv4, 1'b0);
        end
        @(negedge clk);
        chk("lat c4 valid", rv4, 1'b1);
        chk("lat c4 rdata", rd4, 32'hA5A5_A5A5);
        chk("lat c4 fault", rf4, 1'b0);
        chk("lat c4 ready", rdy4, 1'b1);
        @(negedge clk);
        v4 = 1'b0;
        chk("lat c5 store valid", rv4, 1'b1);
        chk("lat c5 store rdata", rd4, 32'h0);
        chk("lat c5 store fault", rf4, 1'b0);
        @(negedge clk);
        chk("lat c6 valid", rv4, 1'b0);
        req4(0, 2'b00, 0, 32'h44, 32'h0, r, f, lat);
        chk("held store data", r, 32'h1122_3344);
        chk("load latency", lat, 4);
        req4(0, 2'b01, 1, 32'h44, 32'h0, r, f, lat);
        chk("l4 lh rdata", r, 32'h0000_3344);

        // Reset in cycle 2 of a pending load, with a store presented
        @(negedge clk);
        v4 = 1'b1; w4 = 1'b0; sz4 = 2'b00; a4 = 32'h40;
        @(negedge clk);
        v4 = 1'b0;
        @(negedge clk);
        rst4_n = 1'b0;
        v4 = 1'b1; w4 = 1'b1; sz4 = 2'b00; a4 = 32'h4C; wd4 = 32'hFFFF_FFFF;
        @(negedge clk);
        rst4_n = 1'b1;
        v4 = 1'b0;
        chk("rst valid", rv4, 1'b0);
        chk("rst fault", rf4, 1'b0);
        chk("rst rdata", rd4, 32'h0);
        chk("rst ready", rdy4, 1'b1);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rv4 !== 1'b0) seen = 1'b1;
        end
        chk("rst no response", seen, 1'b0);
        req4(0, 2'b00, 0, 32'h4C, 32'h0, r, f, lat);
        chk("rst store dropped", r, 32'h0000_004C);
        req4(0, 2'b00, 0, 32'h48, 32'h0, r, f, lat);
        chk("rst data persists", r, 32'h0000_0077);
        chk("rst persist lat", lat, 4);
        req4(0, 2'b00, 0, 32'h42, 32'h0, r, f, lat);
        chk("l4 fault flag", f, 1'b1);
        chk("l4 fault lat", lat, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
